// File: rtl/edge_detect_bank.sv
// rtl/edge_detect_bank.sv - multi-channel synchronised edge detector with sticky flags and event counters
//
// Purpose:
//   Each of CH asynchronous inputs passes through a SYNC_STAGES-flop
//   synchroniser, an optional debounce filter, and an edge detector. A
//   one-cycle pulse is emitted on rise, fall or both edges, selected per
//   channel. Every pulse sets a sticky flag and bumps a saturating counter.
//
// Build option:
//   EDGE_DEBOUNCE_EN - when defined, the filtered level follows the
//   synchronised input only after DB_CYCLES consecutive mismatching cycles.
//   When undefined, level is simply the registered synchroniser output.
//
// Ports:
//   clk      in   1        clock, all logic on posedge
//   rst      in   1        asynchronous active-high reset
//   en       in   1        global enable for pulse/sticky/counter updates
//   din      in   CH       raw asynchronous inputs
//   mode     in   2*CH     per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr      in   CH       per channel: clear sticky flag and counter
//   cnt_sel  in   SEL_W    channel whose counter drives cnt_out
//   level    out  CH       filtered level
//   pulse    out  CH       registered one-cycle edge pulse
//   sticky   out  CH       latched event-seen flag
//   cnt_out  out  CNT_W    counter of channel cnt_sel, 0 when cnt_sel >= CH

module edge_detect_bank #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int CNT_W       = 8,
  parameter int SEL_W       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CH-1:0]     din,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     clr,
  input  logic [SEL_W-1:0]  cnt_sel,
  output logic [CH-1:0]     level,
  output logic [CH-1:0]     pulse,
  output logic [CH-1:0]     sticky,
  output logic [CNT_W-1:0]  cnt_out
);

  if (CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 || CNT_W < 1 || SEL_W < 1) begin : g_bad_param
    $error("edge_detect_bank: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Synchroniser: stage 0 samples din, last stage feeds the filter.
  logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
  logic [CH-1:0]                  sync_out;

  logic [CH-1:0] level_q, level_d;
  logic [CH-1:0] level_dly_q, level_dly_d;
  logic [CH-1:0] pulse_q, pulse_d;
  logic [CH-1:0] sticky_q, sticky_d;
  logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CH-1:0] rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
  localparam int DBC_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_CYCLES - 1);

  logic [CH-1:0][DBC_W-1:0] dbc_q, dbc_d;

  // dbc counts consecutive cycles where the synchronised input disagrees
  // with the filtered level; any agreeing cycle restarts the count.
  always_comb begin
    level_d = level_q;
    dbc_d   = dbc_q;
    for (int i = 0; i < CH; i++) begin
      if (sync_out[i] == level_q[i]) begin
        dbc_d[i] = '0;
      end else if (dbc_q[i] == DBC_LAST) begin
        level_d[i] = sync_out[i];
        dbc_d[i]   = '0;
      end else begin
        dbc_d[i] = dbc_q[i] + DBC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbc_q <= '0;
    end else begin
      dbc_q <= dbc_d;
    end
  end
`else
  always_comb begin
    level_d = sync_out;
  end
`endif

  // Pulse, sticky and counter all act on the pulse being registered this
  // cycle, so sticky/counter become visible together with the pulse and a
  // disabled (en=0) edge never reaches them.
  always_comb begin
    level_dly_d = level_q;
    rise        = level_q & ~level_dly_q;
    fall        = ~level_q & level_dly_q;
    pulse_d     = '0;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    for (int i = 0; i < CH; i++) begin
      pulse_d[i]  = en & ((mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]));
      // A pulse coinciding with clr wins so the event is never lost.
      sticky_d[i] = pulse_d[i] | (sticky_q[i] & ~clr[i]);
      if (clr[i]) begin
        cnt_d[i] = CNT_W'(pulse_d[i]);
      end else if (pulse_d[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < CH; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        cnt_out = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pulse_q     <= '0;
      sticky_q    <= '0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level  = level_q;
  assign pulse  = pulse_q;
  assign sticky = sticky_q;

endmodule

// File: tb/tb_edge_detect_bank.sv
// tb/tb_edge_detect_bank.sv - self-checking bench for edge_detect_bank
module tb_edge_detect_bank;

  localparam int CH    = 4;
  localparam int S     = 2;
  localparam int DB    = 16;
  localparam int CNT_W = 2;
  localparam int SEL_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef EDGE_DEBOUNCE_EN
  localparam int D = DB;
`else
  localparam int D = 1;
`endif
  localparam int HOLD = D + S + 6;
  localparam int MAXN = 16384;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [CH-1:0]    din = '0;
  logic [2*CH-1:0]  mode = '0;
  logic [CH-1:0]    clr = '0;
  logic [SEL_W-1:0] cnt_sel = '0;
  logic [CH-1:0]    level, pulse, sticky;
  logic [CNT_W-1:0] cnt_out;

  int n_checks = 0;
  int n_fail   = 0;

  edge_detect_bank #(
    .CH(CH), .SYNC_STAGES(S), .DB_CYCLES(DB), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .mode(mode), .clr(clr),
    .cnt_sel(cnt_sel), .level(level), .pulse(pulse), .sticky(sticky),
    .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: hist[k] is din as sampled at the k-th edge since reset.
  // The synchronised value after edge k is the din sampled S-1 edges earlier.
  logic [CH-1:0] hist [MAXN];
  int            n = 0;
  logic [CH-1:0] m_level = '0, m_level_old = '0, m_pulse = '0, m_sticky = '0;
  int            m_cnt [CH] = '{default: 0};

  function automatic logic [CH-1:0] hget(input int idx);
    if (idx < 1 || idx >= MAXN) return '0;
    return hist[idx];
  endfunction

  always @(posedge clk or posedge rst) begin : model_blk
    int            nn;
    logic [CH-1:0] nl, rise, fall, p, h;
    logic          run;
    if (rst) begin
      n           <= 0;
      m_level     <= '0;
      m_level_old <= '0;
      m_pulse     <= '0;
      m_sticky    <= '0;
      for (int c = 0; c < CH; c++) m_cnt[c] <= 0;
    end else begin
      nn = n + 1;
`ifdef EDGE_DEBOUNCE_EN
      // Level flips once the last DB synchronised samples all disagree with it.
      nl = m_level;
      for (int c = 0; c < CH; c++) begin
        run = 1'b1;
        for (int j = 1; j <= DB; j++) begin
          h = hget(nn - j - S + 1);
          if (h[c] == m_level[c]) run = 1'b0;
        end
        if (run) nl[c] = ~m_level[c];
      end
`else
      nl = hget(nn - S);
`endif
      rise = m_level & ~m_level_old;
      fall = ~m_level & m_level_old;
      for (int c = 0; c < CH; c++) begin
        p[c] = en & ((mode[2*c] & rise[c]) | (mode[2*c+1] & fall[c]));
        m_sticky[c] <= clr[c] ? p[c] : (m_sticky[c] | p[c]);
        if (clr[c])                      m_cnt[c] <= int'(p[c]);
        else if (p[c] && m_cnt[c] < CMAX) m_cnt[c] <= m_cnt[c] + 1;
      end
      m_level     <= nl;
      m_level_old <= m_level;
      m_pulse     <= p;
      n           <= nn;
      if (nn < MAXN) hist[nn] <= din;
    end
  end

  always @(negedge clk) begin : compare_blk
    int ec;
    if (int'(cnt_sel) < CH) ec = m_cnt[cnt_sel];
    else                    ec = 0;
    chk("cmp_level",  int'(level),   int'(m_level));
    chk("cmp_pulse",  int'(pulse),   int'(m_pulse));
    chk("cmp_sticky", int'(sticky),  int'(m_sticky));
    chk("cmp_cnt",    int'(cnt_out), ec);
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle(input int k);
    repeat (k) cycle();
  endtask

  task automatic peek();
    #5;
  endtask

  task automatic count_pulses(input int ch, input int cycles, output int np, output int nl);
    np = 0;
    nl = 0;
    repeat (cycles) begin
      cycle();
      peek();
      if (pulse[ch]) np++;
      if (level[ch]) nl++;
    end
  endtask

  int hold [CH] = '{default: 0};

  initial begin : stim
    int a, b, la, lb, tot;
    rst = 1'b1;
    settle(3);
    rst = 1'b0;
    peek();
    chk("reset_level",  int'(level),   0);
    chk("reset_sticky", int'(sticky),  0);
    chk("reset_cnt",    int'(cnt_out), 0);
    en   = 1'b1;
    mode = 8'b0000_0001;
    settle(HOLD);

    // Rise on channel 0: level after edge S+D, pulse after edge S+D+1.
    din[0] = 1'b1;
    settle(S + D - 1); peek();
    chk("t1_level_before", int'(level[0]), 0);
    cycle(); peek();
    chk("t1_level_rise",    int'(level[0]), 1);
    chk("t1_pulse_not_yet", int'(pulse[0]), 0);
    cycle(); peek();
    chk("t1_pulse",        int'(pulse[0]), 1);
    chk("t1_model_pulse",  int'(m_pulse[0]), 1);
    chk("t1_sticky",       int'(sticky[0]), 1);
    cycle(); peek();
    chk("t1_pulse_one_cycle", int'(pulse[0]), 0);
    chk("t1_cnt",             int'(cnt_out), 1);

    // Both-edge then fall-only on channel 1.
    mode[3:2] = 2'b11; cnt_sel = 3'd1; clr[1] = 1'b1; cycle(); clr[1] = 1'b0;
    din[1] = 1'b1; count_pulses(1, HOLD, a, la);
    din[1] = 1'b0; count_pulses(1, HOLD, b, lb);
    chk("t2_both_pulses", a + b, 2);
    chk("t2_both_cnt", int'(cnt_out), 2);
    mode[3:2] = 2'b10; clr[1] = 1'b1; cycle(); clr[1] = 1'b0;
    din[1] = 1'b1; count_pulses(1, HOLD, a, la);
    din[1] = 1'b0; count_pulses(1, HOLD, b, lb);
    chk("t2_fall_high_phase", a, 0);
    chk("t2_fall_low_phase",  b, 1);
    chk("t2_fall_cnt", int'(cnt_out), 1);

`ifdef EDGE_DEBOUNCE_EN
    // Glitch one cycle shorter than the window is dropped; a full window passes.
    mode[5:4] = 2'b01; cnt_sel = 3'd2;
    din[2] = 1'b1; settle(D - 1); din[2] = 1'b0;
    count_pulses(2, HOLD + D, a, la);
    chk("t3_glitch_pulse", a, 0);
    chk("t3_glitch_level", la, 0);
    din[2] = 1'b1;
    settle(S + D - 1); peek();
    chk("t3_level_before", int'(level[2]), 0);
    cycle(); peek();
    chk("t3_level_rise", int'(level[2]), 1);
    cycle(); peek();
    chk("t3_pulse", int'(pulse[2]), 1);
    cycle(); peek();
`endif

    // Counter saturation on channel 3, then clr coincident with a pulse.
    mode[7:6] = 2'b01; cnt_sel = 3'd3; clr[3] = 1'b1; cycle(); clr[3] = 1'b0;
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      din[3] = 1'b1; count_pulses(3, HOLD, a, la); tot += a;
      din[3] = 1'b0; count_pulses(3, HOLD, b, lb); tot += b;
    end
    chk("t4_rise_count", tot, 5);
    chk("t4_cnt_sat", int'(cnt_out), 3);
    chk("t4_model_sat", m_cnt[3], 3);
    chk("t4_sticky", int'(sticky[3]), 1);
    din[3] = 1'b1;
    settle(S + D);
    clr[3] = 1'b1;
    cycle();
    clr[3] = 1'b0;
    peek();
    chk("t4_clr_pulse",  int'(pulse[3]), 1);
    chk("t4_clr_cnt",    int'(cnt_out), 1);
    chk("t4_clr_sticky", int'(sticky[3]), 1);
    cnt_sel = 3'd5;
    #1;
    chk("t4_sel_oob", int'(cnt_out), 0);
    cnt_sel = 3'd7;
    #1;
    chk("t4_sel_oob_max", int'(cnt_out), 0);

    // Enable gating on channel 0.
    cnt_sel = 3'd0; clr[0] = 1'b1; cycle(); clr[0] = 1'b0;
    din[0] = 1'b0; count_pulses(0, HOLD, a, la);
    chk("t5_fall_ignored", a, 0);
    en = 1'b0;
    din[0] = 1'b1; count_pulses(0, HOLD, a, la);
    chk("t5_en0_no_pulse", a, 0);
    chk("t5_en0_cnt", int'(cnt_out), 0);
    chk("t5_en0_sticky", int'(sticky[0]), 0);
    chk("t5_level_tracks", int'(level[0]), 1);
    en = 1'b1;
    count_pulses(0, HOLD, a, la);
    chk("t5_reenable_no_pulse", a, 0);
    chk("t5_reenable_cnt", int'(cnt_out), 0);

    // Reset in the middle of a transition, din[0] high through reset.
    din[0] = 1'b0;
    settle(S + D / 2);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_level",  int'(level),   0);
    chk("t6_rst_pulse",  int'(pulse),   0);
    chk("t6_rst_sticky", int'(sticky),  0);
    chk("t6_rst_cnt",    int'(cnt_out), 0);
    din[0] = 1'b1;
    settle(2);
    rst = 1'b0;
    count_pulses(0, HOLD + D, a, la);
    chk("t6_single_pulse", a, 1);
    chk("t6_cnt", int'(cnt_out), 1);
    chk("t6_sticky", int'(sticky[0]), 1);

    // Randomised traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          din[c]  = ~din[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, D + 1)
                                                 : $urandom_range(0, 3 * D + 4);
        end else begin
          hold[c]--;
        end
        clr[c] = ($urandom_range(0, 39) == 0);
      end
      en      = ($urandom_range(0, 9) != 0);
      cnt_sel = SEL_W'($urandom_range(0, 7));
      if (i % 300 == 0) mode = (2*CH)'($urandom);
      if (i % 997 == 500) begin
        #1 rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end
    clr = '0;
    settle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
